// File: rtl/mfp_uart_hex_parser_pkg.sv
// Shared constants for the UART hex programmer: character codes, parser states, default load address.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mfp_uart_hex_parser_pkg;

   // Characters with special meaning in the hex stream
   localparam logic [7:0] CHAR_AT  = 8'h40;
   localparam logic [7:0] CHAR_SP  = 8'h20;
   localparam logic [7:0] CHAR_TAB = 8'h09;
   localparam logic [7:0] CHAR_LF  = 8'h0a;
   localparam logic [7:0] CHAR_CR  = 8'h0d;

   // Parser states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_ADDR = 2'd2;
   localparam logic [1:0] ST_SKIP = 2'd3;

   // Boot vector used as the write address until an '@' token arrives
   localparam logic [31:0] RESET_ADDRESS_DEFAULT = 32'h1fc00000;

   // Classification of one received character
   typedef struct packed {
      logic       is_hex;
      logic [3:0] nibble;
      logic       is_at;
      logic       is_term;
   } char_class_t;

endpackage

// File: rtl/mfp_ascii_hex_decode.sv
// Classifies one ASCII byte as hex digit (with its value), '@', token terminator, or other.
// Latency: combinational.
// Backpressure: none; caller qualifies the byte.
module mfp_ascii_hex_decode
   import mfp_uart_hex_parser_pkg::*;
(
   input  logic [7:0] byte_data,
   output logic       is_hex,
   output logic [3:0] nibble,
   output logic       is_at,
   output logic       is_term
);

   // Digits keep their low nibble; letters a-f/A-F share low nibbles 1..6, so add 9
   always_comb begin
      is_hex  = 1'b0;
      nibble  = 4'h0;
      is_at   = (byte_data == CHAR_AT);
      is_term = (byte_data == CHAR_SP) || (byte_data == CHAR_TAB) ||
                (byte_data == CHAR_LF) || (byte_data == CHAR_CR);
      if (byte_data >= 8'h30 && byte_data <= 8'h39) begin
         is_hex = 1'b1;
         nibble = byte_data[3:0];
      end else if ((byte_data >= 8'h61 && byte_data <= 8'h66) ||
                   (byte_data >= 8'h41 && byte_data <= 8'h46)) begin
         is_hex = 1'b1;
         nibble = byte_data[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/mfp_uart_hex_parser.sv
// Parses ASCII hex text ("@addr" tokens and data tokens) into 32-bit word-write requests.
// Latency: terminator byte in cycle N -> write_valid in cycle N+1.
// Backpressure: request held until write_ready; bytes arriving while stalled are dropped and flagged.
module mfp_uart_hex_parser
   import mfp_uart_hex_parser_pkg::*;
#(
   parameter logic [31:0] RESET_ADDRESS = RESET_ADDRESS_DEFAULT,
   parameter int          MAX_DIGITS    = 8
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  byte_data,
   input  logic        byte_ready,
   output logic [31:0] write_address,
   output logic [31:0] write_data,
   output logic        write_valid,
   input  logic        write_ready,
   output logic        format_error,
   output logic        overflow_error,
   output logic [15:0] word_count
);

   char_class_t cls;
   logic [1:0]  state, state_nxt;
   logic [31:0] acc, acc_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        stall, accept, take;
   logic        set_ferr, word_done, addr_load;

   mfp_ascii_hex_decode u_decode (
      .byte_data (byte_data),
      .is_hex    (cls.is_hex),
      .nibble    (cls.nibble),
      .is_at     (cls.is_at),
      .is_term   (cls.is_term)
   );

   assign stall  = write_valid & ~write_ready;
   assign accept = write_valid &  write_ready;
   assign take   = byte_ready  & ~stall;

   // Token parser: next state, accumulator and digit count for an accepted byte
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      set_ferr  = 1'b0;
      word_done = 1'b0;
      addr_load = 1'b0;
      if (take) begin
         case (state)
            ST_IDLE: begin
               if (cls.is_hex) begin
                  acc_nxt   = {28'b0, cls.nibble};
                  cnt_nxt   = 4'd1;
                  state_nxt = ST_DATA;
               end else if (cls.is_at) begin
                  acc_nxt   = 32'b0;
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_ADDR;
               end else if (!cls.is_term) begin
                  set_ferr  = 1'b1;
                  state_nxt = ST_SKIP;
               end
            end
            ST_DATA, ST_ADDR: begin
               if (cls.is_hex) begin
                  if (cnt == 4'(MAX_DIGITS)) begin
                     set_ferr  = 1'b1;
                     state_nxt = ST_SKIP;
                  end else begin
                     acc_nxt = {acc[27:0], cls.nibble};
                     cnt_nxt = cnt + 4'd1;
                  end
               end else if (cls.is_term) begin
                  state_nxt = ST_IDLE;
                  if (state == ST_DATA) begin
                     word_done = 1'b1;
                  end else if (cnt == 4'd0) begin
                     set_ferr = 1'b1;
                  end else begin
                     addr_load = 1'b1;
                  end
               end else begin
                  set_ferr  = 1'b1;
                  state_nxt = ST_SKIP;
               end
            end
            default: begin
               if (cls.is_term) state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Parser state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         acc   <= 32'b0;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Write request: a newly completed word wins over clearing on accept; address load wins over +4
   always_ff @(posedge clock) begin
      if (reset) begin
         write_valid   <= 1'b0;
         write_data    <= 32'b0;
         write_address <= RESET_ADDRESS;
      end else begin
         if (word_done) begin
            write_valid <= 1'b1;
            write_data  <= acc;
         end else if (accept) begin
            write_valid <= 1'b0;
         end
         if (addr_load) begin
            write_address <= {acc[31:2], 2'b00};
         end else if (accept) begin
            write_address <= write_address + 32'd4;
         end
      end
   end

   // Sticky error flags and accepted-word counter
   always_ff @(posedge clock) begin
      if (reset) begin
         format_error   <= 1'b0;
         overflow_error <= 1'b0;
         word_count     <= 16'd0;
      end else begin
         if (set_ferr)            format_error   <= 1'b1;
         if (byte_ready && stall) overflow_error <= 1'b1;
         if (accept)              word_count     <= word_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_mfp_uart_hex_parser.sv
// Self-checking bench for the UART hex parser: directed scenarios plus a randomized token stream.
// Latency: checks sample one time unit after the active edge.
// Backpressure: write_ready is driven per byte; the reference model predicts dropped bytes.
module tb_mfp_uart_hex_parser;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready = 1'b0;
   logic        write_ready = 1'b0;
   logic [31:0] write_address, write_data;
   logic        write_valid, format_error, overflow_error;
   logic [15:0] word_count;

   int checks = 0;
   int passes = 0;

   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];

   // Reference model: token-level parsing plus the request/accept handshake
   logic [31:0] m_addr, m_data;
   logic        m_pending, m_ferr, m_ovf;
   logic [15:0] m_count;
   logic [7:0]  tok[$];

   always #5 clock = ~clock;

   mfp_uart_hex_parser dut (
      .clock          (clock),
      .reset          (reset),
      .byte_data      (byte_data),
      .byte_ready     (byte_ready),
      .write_address  (write_address),
      .write_data     (write_data),
      .write_valid    (write_valid),
      .write_ready    (write_ready),
      .format_error   (format_error),
      .overflow_error (overflow_error),
      .word_count     (word_count)
   );

   // Record every transfer the DUT is about to make at the coming rising edge
   always @(negedge clock) begin
      if (!reset && write_valid && write_ready) got_q.push_back({write_address, write_data});
   end

   function automatic int hexval(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
   endfunction

   function automatic logic is_term(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h09) || (c == 8'h0a) || (c == 8'h0d);
   endfunction

   task automatic model_reset();
      m_addr = 32'h1fc00000; m_data = 0; m_pending = 0; m_ferr = 0; m_ovf = 0; m_count = 0;
      tok.delete(); exp_q.delete(); got_q.delete();
   endtask

   // One clock cycle of the model with the inputs present at that edge
   task automatic model_step(input logic [7:0] b, input logic br, input logic wr);
      int kind, start, n, d;
      logic [31:0] val;
      if (m_pending && !wr) begin
         if (br) m_ovf = 1;
         return;
      end
      if (m_pending) begin
         exp_q.push_back({m_addr, m_data});
         m_addr += 4; m_count += 1; m_pending = 0;
      end
      if (!br) return;
      if (!is_term(b)) begin
         tok.push_back(b);
         return;
      end
      kind = 0; val = 0;
      if (tok.size() > 0) begin
         start = (tok[0] == 8'h40) ? 1 : 0;
         n = tok.size() - start;
         kind = (start == 1) ? 2 : 1;
         if (n < 1 || n > 8) kind = 3;
         for (int i = start; i < tok.size(); i++) begin
            d = hexval(tok[i]);
            if (d < 0) kind = 3;
            else val = val * 16 + d;
         end
      end
      if (kind == 1) begin m_data = val; m_pending = 1; end
      else if (kind == 2) m_addr = {val[31:2], 2'b00};
      else if (kind == 3) m_ferr = 1;
      tok.delete();
   endtask

   task automatic apply_reset();
      reset = 1; byte_ready = 0; write_ready = 0;
      @(posedge clock); #1;
      reset = 0;
      model_reset();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic wr);
      byte_data = b; byte_ready = 1; write_ready = wr;
      model_step(b, 1'b1, wr);
      @(posedge clock); #1;
      byte_ready = 0;
   endtask

   task automatic idle(input logic wr);
      byte_ready = 0; write_ready = wr;
      model_step(8'h00, 1'b0, wr);
      @(posedge clock); #1;
   endtask

   task automatic send_str(input string s, input logic wr);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], wr);
   endtask

   task automatic test_reset();
      reset = 1; byte_ready = 1; byte_data = "@"; write_ready = 1;
      apply_reset();
      checks++; if (write_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", write_valid); else passes++;
      checks++; if (write_data !== 32'h0) $display("FAIL reset_data got %h want 0", write_data); else passes++;
      checks++; if (write_address !== 32'h1fc00000) $display("FAIL reset_addr got %h want 1fc00000", write_address); else passes++;
      checks++; if (format_error !== 1'b0 || overflow_error !== 1'b0)
         $display("FAIL reset_errors got %b%b want 00", format_error, overflow_error); else passes++;
      checks++; if (word_count !== 16'd0) $display("FAIL reset_count got %0d want 0", word_count); else passes++;
   endtask

   task automatic test_basic();
      apply_reset();
      send_str("@00000100\n", 1);
      send_str("DEADBEEF ", 1);
      checks++; if (write_valid !== 1'b1) $display("FAIL basic_latency valid got %b want 1", write_valid); else passes++;
      checks++; if (write_address !== 32'h100 || write_data !== 32'hdeadbeef)
         $display("FAIL basic_req got %h/%h want 00000100/deadbeef", write_address, write_data); else passes++;
      idle(1);
      checks++; if (write_valid !== 1'b0 || word_count !== 16'd1)
         $display("FAIL basic_accept valid/count got %b/%0d want 0/1", write_valid, word_count); else passes++;
      checks++; if (got_q.size() != 1 || got_q[0] !== {32'h100, 32'hdeadbeef})
         $display("FAIL basic_writes got %0d writes first %h want 1 write 00000100deadbeef",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0); else passes++;
   endtask

   task automatic test_multi();
      logic [63:0] want[3] = '{{32'h1fc00000, 32'h1}, {32'h1fc00004, 32'h2}, {32'h1fc00008, 32'h3}};
      apply_reset();
      send_str("1 2 3\r\n", 1);
      idle(1); idle(1);
      checks++; if (got_q.size() != 3) $display("FAIL multi_count got %0d writes want 3", got_q.size()); else passes++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== want[i])
            $display("FAIL multi_write%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'h0, want[i]);
         else passes++;
      end
      checks++; if (word_count !== 16'd3 || write_address !== 32'h1fc0000c || format_error !== 1'b0)
         $display("FAIL multi_state got %0d/%h/%b want 3/1fc0000c/0", word_count, write_address, format_error); else passes++;
   endtask

   task automatic test_stall();
      apply_reset();
      send_str("AA", 1);
      send_byte(" ", 0);
      send_str("BB ", 0);
      checks++; if (write_valid !== 1'b1 || write_data !== 32'haa || write_address !== 32'h1fc00000)
         $display("FAIL stall_hold got %b/%h/%h want 1/000000aa/1fc00000", write_valid, write_data, write_address); else passes++;
      checks++; if (overflow_error !== 1'b1) $display("FAIL stall_overflow got %b want 1", overflow_error); else passes++;
      idle(1); idle(1);
      checks++; if (write_valid !== 1'b0 || write_address !== 32'h1fc00004 || word_count !== 16'd1)
         $display("FAIL stall_release got %b/%h/%0d want 0/1fc00004/1", write_valid, write_address, word_count); else passes++;
      checks++; if (got_q.size() != 1 || got_q[0] !== {32'h1fc00000, 32'haa})
         $display("FAIL stall_writes got %0d writes first %h want 1 write 1fc00000000000aa",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0); else passes++;
   endtask

   task automatic test_too_many_digits();
      apply_reset();
      send_str("123456789 ", 1);
      checks++; if (format_error !== 1'b1 || write_valid !== 1'b0)
         $display("FAIL digits_error ferr/valid got %b/%b want 1/0", format_error, write_valid); else passes++;
      send_str("55 ", 1);
      idle(1); idle(1);
      checks++; if (got_q.size() != 1 || got_q[0] !== {32'h1fc00000, 32'h55})
         $display("FAIL digits_writes got %0d writes first %h want 1 write 1fc0000000000055",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0); else passes++;
   endtask

   task automatic test_address_rules();
      apply_reset();
      send_str("@10000003 7 ", 1);
      idle(1); idle(1);
      checks++; if (format_error !== 1'b0) $display("FAIL addr_noerr got %b want 0", format_error); else passes++;
      send_str("G1 @ ", 1);
      idle(1);
      checks++; if (format_error !== 1'b1 || write_address !== 32'h10000004 || word_count !== 16'd1)
         $display("FAIL addr_bad got %b/%h/%0d want 1/10000004/1", format_error, write_address, word_count); else passes++;
      checks++; if (got_q.size() != 1 || got_q[0] !== {32'h10000000, 32'h7})
         $display("FAIL addr_writes got %0d writes first %h want 1 write 1000000000000007",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0); else passes++;
   endtask

   task automatic test_reset_mid_token();
      apply_reset();
      send_str("@00000200\n12", 1);
      apply_reset();
      send_str("9 ", 1);
      idle(1); idle(1);
      checks++; if (format_error !== 1'b0 || overflow_error !== 1'b0)
         $display("FAIL midreset_errors got %b%b want 00", format_error, overflow_error); else passes++;
      checks++; if (got_q.size() != 1 || got_q[0] !== {32'h1fc00000, 32'h9})
         $display("FAIL midreset_writes got %0d writes first %h want 1 write 1fc0000000000009",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0); else passes++;
   endtask

   task automatic test_random();
      logic [7:0] terms[4] = '{8'h20, 8'h09, 8'h0a, 8'h0d};
      string s;
      int k, n, d;
      logic [7:0] c;
      apply_reset();
      for (int t = 0; t < 80; t++) begin
         k = $urandom_range(0, 9);
         s = "";
         if (k <= 5) n = $urandom_range(1, 8);
         else if (k <= 7) begin s = "@"; n = $urandom_range(1, 8); end
         else if (k == 8) n = 9;
         else begin s = ($urandom_range(0, 1) == 1) ? "@" : "g"; n = $urandom_range(0, 2); end
         for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, 15);
            if (d < 10) c = 8'(48 + d);
            else c = ($urandom_range(0, 1) == 1) ? 8'(87 + d) : 8'(55 + d);
            s = $sformatf("%s%c", s, c);
         end
         s = $sformatf("%s%c", s, terms[$urandom_range(0, 3)]);
         if ($urandom_range(0, 3) == 0) s = $sformatf("%s%c", s, terms[$urandom_range(0, 3)]);
         for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 4) == 0) idle(($urandom_range(0, 1) == 1));
         end
      end
      idle(1); idle(1); idle(1);
      checks++; if (got_q.size() != exp_q.size())
         $display("FAIL rand_count got %0d writes want %0d", got_q.size(), exp_q.size()); else passes++;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i])
            $display("FAIL rand_write%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'h0, exp_q[i]);
         else passes++;
      end
      checks++; if (format_error !== m_ferr || overflow_error !== m_ovf)
         $display("FAIL rand_flags got %b%b want %b%b", format_error, overflow_error, m_ferr, m_ovf); else passes++;
      checks++; if (word_count !== m_count || write_address !== m_addr || write_valid !== m_pending)
         $display("FAIL rand_state got %0d/%h/%b want %0d/%h/%b",
                  word_count, write_address, write_valid, m_count, m_addr, m_pending); else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_stall();
      test_too_many_digits();
      test_address_rules();
      test_reset_mid_token();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
